// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its arbiter: ALU op-code encodings,
// flag bit positions within the packed 4-bit flag vector, and port ids.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALUC_AND = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0110;
    localparam logic [3:0] ALUC_NOR = 4'b0111;
    localparam logic [3:0] ALUC_LUI = 4'b1000;
    localparam logic [3:0] ALUC_SLT = 4'b1011;
    localparam logic [3:0] ALUC_SRA = 4'b1100;
    localparam logic [3:0] ALUC_SRL = 4'b1101;
    localparam logic [3:0] ALUC_SLL = 4'b1110;

    localparam int unsigned NUM_FLAGS = 4;
    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_OVF   = 3;

    typedef enum logic {
        PortMain = 1'b0,
        PortAddr = 1'b1
    } port_e;

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic zero,
                                                         input logic carry,
                                                         input logic negative,
                                                         input logic overflow);
        logic [NUM_FLAGS-1:0] f;
        f            = '0;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        f[FLAG_NEG]   = negative;
        f[FLAG_OVF]   = overflow;
        return f;
    endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// ----------------------------------------------------------------------------
// alu_rsp_slot
// One-entry result holding slot with a valid/ready output handshake.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   capture_i           load cap_r_i/cap_flags_i this cycle (sets valid)
//   cap_r_i, cap_flags_i  result and flags to capture
//   rsp_ready_i         consumer takes the held result when valid
//   rsp_valid_o         slot full
//   rsp_r_o, rsp_flags_o  held result and flags
// ----------------------------------------------------------------------------
module alu_rsp_slot
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 capture_i,
    input  logic [DATA_W-1:0]    cap_r_i,
    input  logic [NUM_FLAGS-1:0] cap_flags_i,
    input  logic                 rsp_ready_i,
    output logic                 rsp_valid_o,
    output logic [DATA_W-1:0]    rsp_r_o,
    output logic [NUM_FLAGS-1:0] rsp_flags_o
);

    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    r_q, r_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;

    always_comb begin
        valid_d = valid_q;
        r_d     = r_q;
        flags_d = flags_q;
        // The arbiter never issues to a full, undrained slot, so capture and
        // drain never collide; capture still takes priority for safety.
        if (capture_i) begin
            valid_d = 1'b1;
            r_d     = cap_r_i;
            flags_d = cap_flags_i;
        end else if (valid_q && rsp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            r_q     <= '0;
            flags_q <= '0;
        end else begin
            valid_q <= valid_d;
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_r_o     = r_q;
    assign rsp_flags_o = flags_q;

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters (port 0 main
// datapath, port 1 address/branch unit). Round-robin grant, registered ALU
// operands, and a per-port result slot. Latency accept -> rsp_valid is 2.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/aluc     request handshake and operands (N=0,1)
//   rspN_valid/ready/r/flags      response handshake, result, flags
//                                 flags = {overflow,negative,carry,zero}
//   alu_a/alu_b/alu_aluc          registered operands driven to the ALU
//   alu_r/zero/carry/negative/overflow  ALU outputs
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_W-1:0]    req0_a,
    input  logic [DATA_W-1:0]    req0_b,
    input  logic [OP_W-1:0]      req0_aluc,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_W-1:0]    req1_a,
    input  logic [DATA_W-1:0]    req1_b,
    input  logic [OP_W-1:0]      req1_aluc,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [DATA_W-1:0]    rsp0_r,
    output logic [NUM_FLAGS-1:0] rsp0_flags,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [DATA_W-1:0]    rsp1_r,
    output logic [NUM_FLAGS-1:0] rsp1_flags,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [OP_W-1:0]      alu_aluc,
    input  logic [DATA_W-1:0]    alu_r,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    input  logic                 alu_negative,
    input  logic                 alu_overflow
);

    port_e               last_grant_q, last_grant_d;
    port_e               tag_q, tag_d;
    logic                inflight_q, inflight_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_aluc_q, alu_aluc_d;

    logic inflight0, inflight1;
    logic elig0, elig1;
    logic grant0, grant1;
    logic [NUM_FLAGS-1:0] alu_flags;

    assign inflight0 = inflight_q && (tag_q == PortMain);
    assign inflight1 = inflight_q && (tag_q == PortAddr);

    // A port may issue only if its slot will be free when the result lands:
    // empty now, or being drained this cycle.
    assign elig0 = req0_valid && !inflight0 && (!rsp0_valid || rsp0_ready);
    assign elig1 = req1_valid && !inflight1 && (!rsp1_valid || rsp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            grant1 = elig1 && (!elig0 || (last_grant_q == PortMain));
            grant0 = elig0 && !grant1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        inflight_d   = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_aluc_d   = alu_aluc_q;
        if (grant0) begin
            last_grant_d = PortMain;
            tag_d        = PortMain;
            inflight_d   = 1'b1;
            alu_a_d      = req0_a;
            alu_b_d      = req0_b;
            alu_aluc_d   = req0_aluc;
        end else if (grant1) begin
            last_grant_d = PortAddr;
            tag_d        = PortAddr;
            inflight_d   = 1'b1;
            alu_a_d      = req1_a;
            alu_b_d      = req1_b;
            alu_aluc_d   = req1_aluc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PortAddr;
            tag_q        <= PortMain;
            inflight_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_aluc_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            inflight_q   <= inflight_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_aluc_q   <= alu_aluc_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_aluc = alu_aluc_q;

    assign alu_flags = pack_flags(alu_zero, alu_carry, alu_negative, alu_overflow);

    alu_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_slot0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .capture_i   (inflight0),
        .cap_r_i     (alu_r),
        .cap_flags_i (alu_flags),
        .rsp_ready_i (rsp0_ready),
        .rsp_valid_o (rsp0_valid),
        .rsp_r_o     (rsp0_r),
        .rsp_flags_o (rsp0_flags)
    );

    alu_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_slot1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .capture_i   (inflight1),
        .cap_r_i     (alu_r),
        .cap_flags_i (alu_flags),
        .rsp_ready_i (rsp1_ready),
        .rsp_valid_o (rsp1_valid),
        .rsp_r_o     (rsp1_r),
        .rsp_flags_o (rsp1_flags)
    );

endmodule
